// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one synchronous-read memory port between a fetch
// requester and a load/store requester; one access in flight, registered memory controls.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_rsp_valid,
  output logic                    if_rsp_err,
  output logic [DATA_WIDTH-1:0]   if_rdata,
  input  logic                    ls_req,
  input  logic                    ls_we,
  input  logic [ADDR_WIDTH-1:0]   ls_addr,
  input  logic [DATA_WIDTH-1:0]   ls_wdata,
  input  logic [DATA_WIDTH/8-1:0] ls_be,
  output logic                    ls_rsp_valid,
  output logic [DATA_WIDTH-1:0]   ls_rdata,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_write_data,
  output logic                    mem_write_enable,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  input  logic [DATA_WIDTH-1:0]   mem_read_data
);
  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    last_ls_q, last_ls_d;
  logic                    misalign_q, misalign_d;
  logic                    store_q, store_d;
  logic [CW-1:0]           lat_q, lat_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    mem_we_q, mem_we_d;
  logic [BW-1:0]           mem_be_q, mem_be_d;
  logic                    if_rsp_valid_q, if_rsp_valid_d;
  logic                    if_rsp_err_q, if_rsp_err_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic                    ls_rsp_valid_q, ls_rsp_valid_d;
  logic [DATA_WIDTH-1:0]   ls_rdata_q, ls_rdata_d;
  logic                    pick_ls;

  // Loads and stores are word accesses; the low address bits carry no meaning.
  logic unused_ls_addr;
  assign unused_ls_addr = ^ls_addr[1:0];

  always_comb begin
    state_d        = state_q;
    last_ls_d      = last_ls_q;
    misalign_d     = misalign_q;
    store_d        = store_q;
    lat_d          = lat_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    mem_we_d       = mem_we_q;
    mem_be_d       = mem_be_q;
    if_rsp_valid_d = 1'b0;
    if_rsp_err_d   = 1'b0;
    if_rdata_d     = if_rdata_q;
    ls_rsp_valid_d = 1'b0;
    ls_rdata_d     = ls_rdata_q;
    // On a tie the side that did not win last time is served.
    pick_ls        = ls_req && !(if_req && last_ls_q);
    case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          state_d   = ISSUE;
          last_ls_d = pick_ls;
          if (pick_ls) begin
            misalign_d  = 1'b0;
            store_d     = ls_we;
            mem_addr_d  = {ls_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata_d = ls_wdata;
            mem_we_d    = ls_we;
            mem_be_d    = ls_we ? ls_be : '0;
          end else if (if_addr[1:0] != 2'b00) begin
            misalign_d = 1'b1;
            store_d    = 1'b0;
          end else begin
            misalign_d = 1'b0;
            store_d    = 1'b0;
            mem_addr_d = if_addr;
            mem_we_d   = 1'b0;
            mem_be_d   = '0;
          end
        end
      end
      ISSUE: begin
        mem_we_d = 1'b0;
        if (misalign_q) begin
          state_d        = RESP;
          if_rsp_valid_d = 1'b1;
          if_rsp_err_d   = 1'b1;
          if_rdata_d     = '0;
        end else begin
          state_d = WAIT;
          lat_d   = CW'(MEM_LATENCY - 1);
        end
      end
      WAIT: begin
        if (lat_q == '0) begin
          state_d = RESP;
          if (last_ls_q) begin
            ls_rsp_valid_d = 1'b1;
            ls_rdata_d     = store_q ? '0 : mem_read_data;
          end else begin
            if_rsp_valid_d = 1'b1;
            if_rdata_d     = mem_read_data;
          end
        end else begin
          lat_d = lat_q - CW'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_ls_q      <= 1'b1;
      misalign_q     <= 1'b0;
      store_q        <= 1'b0;
      lat_q          <= '0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_we_q       <= 1'b0;
      mem_be_q       <= '0;
      if_rsp_valid_q <= 1'b0;
      if_rsp_err_q   <= 1'b0;
      if_rdata_q     <= '0;
      ls_rsp_valid_q <= 1'b0;
      ls_rdata_q     <= '0;
    end else begin
      state_q        <= state_d;
      last_ls_q      <= last_ls_d;
      misalign_q     <= misalign_d;
      store_q        <= store_d;
      lat_q          <= lat_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_we_q       <= mem_we_d;
      mem_be_q       <= mem_be_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      if_rsp_err_q   <= if_rsp_err_d;
      if_rdata_q     <= if_rdata_d;
      ls_rsp_valid_q <= ls_rsp_valid_d;
      ls_rdata_q     <= ls_rdata_d;
    end
  end

  assign if_rsp_valid     = if_rsp_valid_q;
  assign if_rsp_err       = if_rsp_err_q;
  assign if_rdata         = if_rdata_q;
  assign ls_rsp_valid     = ls_rsp_valid_q;
  assign ls_rdata         = ls_rdata_q;
  assign mem_address      = mem_addr_q;
  assign mem_write_data   = mem_wdata_q;
  assign mem_write_enable = mem_we_q;
  assign mem_byte_enable  = mem_be_q;

  // While an access is in flight its owner must keep requesting until the response.
  a_req_held: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q != IDLE) |-> (last_ls_q ? ls_req : if_req));
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 with MEM_LATENCY=1, instance 1 with MEM_LATENCY=3,
// each against a small synchronous memory and a cycle-scheduled transaction model.
module tb_mem_port_arbiter;
  logic        clk, rst_n;
  logic        if_req [2];
  logic [31:0] if_addr [2];
  logic        if_rsp_valid [2];
  logic        if_rsp_err [2];
  logic [31:0] if_rdata [2];
  logic        ls_req [2];
  logic        ls_we [2];
  logic [31:0] ls_addr [2];
  logic [31:0] ls_wdata [2];
  logic [3:0]  ls_be [2];
  logic        ls_rsp_valid [2];
  logic [31:0] ls_rdata [2];
  logic [31:0] mem_address [2];
  logic [31:0] mem_write_data [2];
  logic        mem_write_enable [2];
  logic [3:0]  mem_byte_enable [2];
  logic [31:0] mem_read_data [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(1)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req[0]), .if_addr(if_addr[0]), .if_rsp_valid(if_rsp_valid[0]),
    .if_rsp_err(if_rsp_err[0]), .if_rdata(if_rdata[0]),
    .ls_req(ls_req[0]), .ls_we(ls_we[0]), .ls_addr(ls_addr[0]), .ls_wdata(ls_wdata[0]),
    .ls_be(ls_be[0]), .ls_rsp_valid(ls_rsp_valid[0]), .ls_rdata(ls_rdata[0]),
    .mem_address(mem_address[0]), .mem_write_data(mem_write_data[0]),
    .mem_write_enable(mem_write_enable[0]), .mem_byte_enable(mem_byte_enable[0]),
    .mem_read_data(mem_read_data[0]));

  mem_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_LATENCY(3)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req[1]), .if_addr(if_addr[1]), .if_rsp_valid(if_rsp_valid[1]),
    .if_rsp_err(if_rsp_err[1]), .if_rdata(if_rdata[1]),
    .ls_req(ls_req[1]), .ls_we(ls_we[1]), .ls_addr(ls_addr[1]), .ls_wdata(ls_wdata[1]),
    .ls_be(ls_be[1]), .ls_rsp_valid(ls_rsp_valid[1]), .ls_rdata(ls_rdata[1]),
    .mem_address(mem_address[1]), .mem_write_data(mem_write_data[1]),
    .mem_write_enable(mem_write_enable[1]), .mem_byte_enable(mem_byte_enable[1]),
    .mem_read_data(mem_read_data[1]));

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'h1000_0000 | 32'(i);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // ---------------- memories attached to the DUT ports ----------------
  logic [31:0] mem [2][64];
  logic [31:0] rd_pipe [2][3];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        for (int i = 0; i < 64; i++) mem[k][i] <= init_word(i);
        for (int s = 0; s < 3; s++) rd_pipe[k][s] <= '0;
      end else begin
        rd_pipe[k][0] <= mem[k][mem_address[k][7:2]];
        rd_pipe[k][1] <= rd_pipe[k][0];
        rd_pipe[k][2] <= rd_pipe[k][1];
        if (mem_write_enable[k])
          for (int b = 0; b < 4; b++)
            if (mem_byte_enable[k][b])
              mem[k][mem_address[k][7:2]][8*b +: 8] <= mem_write_data[k][8*b +: 8];
      end
    end
  end
  assign mem_read_data[0] = rd_pipe[0][0];
  assign mem_read_data[1] = rd_pipe[1][2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction model + scoreboard ----------------
  logic [31:0] exp_mem [2][64];
  bit          pend_v [2], pend_ls [2], pend_store [2], pend_err [2], last_ls [2];
  int          pend_issue [2], pend_rsp [2], free_c [2];
  logic [31:0] pend_addr [2], pend_wdata [2], pend_data [2];
  logic [3:0]  pend_be [2];

  task automatic model_step(input int k);
    bit e_if, e_ls, e_we, take_ls;
    e_if = pend_v[k] && pend_rsp[k] == cyc && !pend_ls[k];
    e_ls = pend_v[k] && pend_rsp[k] == cyc && pend_ls[k];
    e_we = pend_v[k] && pend_store[k] && pend_issue[k] == cyc;
    chk($sformatf("d%0d if_rsp_valid c%0d", k, cyc), 32'(if_rsp_valid[k]), 32'(e_if));
    chk($sformatf("d%0d ls_rsp_valid c%0d", k, cyc), 32'(ls_rsp_valid[k]), 32'(e_ls));
    chk($sformatf("d%0d mem_we c%0d", k, cyc), 32'(mem_write_enable[k]), 32'(e_we));
    if (pend_v[k] && pend_issue[k] == cyc && !pend_err[k]) begin
      chk($sformatf("d%0d mem_address c%0d", k, cyc), mem_address[k], pend_addr[k]);
      chk($sformatf("d%0d mem_be c%0d", k, cyc), 32'(mem_byte_enable[k]),
          32'(pend_store[k] ? pend_be[k] : 4'h0));
    end
    if (e_we) chk($sformatf("d%0d mem_wdata c%0d", k, cyc), mem_write_data[k], pend_wdata[k]);
    if (e_if) begin
      chk($sformatf("d%0d if_rdata c%0d", k, cyc), if_rdata[k], pend_data[k]);
      chk($sformatf("d%0d if_rsp_err c%0d", k, cyc), 32'(if_rsp_err[k]), 32'(pend_err[k]));
    end
    if (e_ls) begin
      chk($sformatf("d%0d ls_rdata c%0d", k, cyc), ls_rdata[k], pend_data[k]);
      if (pend_store[k])
        exp_mem[k][pend_addr[k][7:2]] = merge(exp_mem[k][pend_addr[k][7:2]], pend_wdata[k], pend_be[k]);
    end
    if (pend_v[k] && pend_rsp[k] == cyc) begin
      pend_v[k] = 0;
      free_c[k] = cyc + 1;
    end
    if (!pend_v[k] && cyc >= free_c[k] && (if_req[k] || ls_req[k])) begin
      take_ls       = ls_req[k] && !(if_req[k] && last_ls[k]);
      last_ls[k]    = take_ls;
      pend_v[k]     = 1;
      pend_ls[k]    = take_ls;
      pend_issue[k] = cyc + 1;
      pend_err[k]   = 0;
      pend_store[k] = 0;
      pend_rsp[k]   = cyc + 2 + lat_of(k);
      if (take_ls) begin
        pend_store[k] = ls_we[k];
        pend_addr[k]  = {ls_addr[k][31:2], 2'b00};
        pend_wdata[k] = ls_wdata[k];
        pend_be[k]    = ls_be[k];
        pend_data[k]  = ls_we[k] ? 32'h0 : exp_mem[k][ls_addr[k][7:2]];
      end else if (if_addr[k][1:0] != 2'b00) begin
        pend_err[k]  = 1;
        pend_data[k] = 32'h0;
        pend_rsp[k]  = cyc + 2;
      end else begin
        pend_addr[k] = if_addr[k];
        pend_data[k] = exp_mem[k][if_addr[k][7:2]];
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      cyc = 0;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("d%0d reset if_rsp_valid", k), 32'(if_rsp_valid[k]), 32'h0);
        chk($sformatf("d%0d reset ls_rsp_valid", k), 32'(ls_rsp_valid[k]), 32'h0);
        chk($sformatf("d%0d reset mem_we", k), 32'(mem_write_enable[k]), 32'h0);
        chk($sformatf("d%0d reset mem_address", k), mem_address[k], 32'h0);
        pend_v[k]  = 0;
        free_c[k]  = 0;
        last_ls[k] = 1;
        for (int i = 0; i < 64; i++) exp_mem[k][i] = init_word(i);
      end
    end else begin
      cyc = cyc + 1;
      for (int k = 0; k < 2; k++) model_step(k);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fetch(input int k, input logic [31:0] a, output int t0, output int tr,
                       output logic [31:0] d, output logic e);
    @(posedge clk); #1;
    if_req[k] = 1'b1; if_addr[k] = a;
    @(negedge clk); #1;
    t0 = cyc; tr = -1; d = 32'hx; e = 1'bx;
    for (int i = 0; i < 20; i++) begin
      if (if_rsp_valid[k]) begin tr = cyc; d = if_rdata[k]; e = if_rsp_err[k]; break; end
      @(negedge clk); #1;
    end
    if (tr < 0) begin
      checks++; errors++;
      $display("FAIL fetch_timeout d%0d addr %h: no if_rsp_valid within 20 cycles", k, a);
    end
    @(posedge clk); #1;
    if_req[k] = 1'b0;
  endtask

  task automatic ls_op(input int k, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, output int t0, output int tr, output logic [31:0] d,
                       output int we_cnt, output logic [31:0] rd4);
    @(posedge clk); #1;
    ls_req[k] = 1'b1; ls_we[k] = we; ls_addr[k] = a; ls_wdata[k] = wd; ls_be[k] = be;
    @(negedge clk); #1;
    t0 = cyc; tr = -1; d = 32'hx; we_cnt = 0; rd4 = 32'hx;
    for (int i = 0; i < 20; i++) begin
      if (mem_write_enable[k]) we_cnt++;
      if (cyc == t0 + 4) rd4 = mem_read_data[k];
      if (ls_rsp_valid[k]) begin tr = cyc; d = ls_rdata[k]; break; end
      @(negedge clk); #1;
    end
    if (tr < 0) begin
      checks++; errors++;
      $display("FAIL ls_timeout d%0d addr %h: no ls_rsp_valid within 20 cycles", k, a);
    end
    @(posedge clk); #1;
    ls_req[k] = 1'b0; ls_we[k] = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  int          t0, tr, wc, n;
  logic [31:0] d, rd4;
  logic        e;
  int          side [4], rc [4];
  logic [31:0] rdv [4];

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if_req[k] = 0; if_addr[k] = 0; ls_req[k] = 0; ls_we[k] = 0;
      ls_addr[k] = 0; ls_wdata[k] = 0; ls_be[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // reset in the middle of a store's issue cycle
    @(posedge clk); #1;
    ls_req[0] = 1; ls_we[0] = 1; ls_addr[0] = 32'h20; ls_wdata[0] = 32'hCAFEF00D; ls_be[0] = 4'hF;
    @(negedge clk);
    @(negedge clk); #1;
    chk("t1 we in issue", 32'(mem_write_enable[0]), 32'h1);
    #1 rst_n = 1'b0; ls_req[0] = 0; ls_we[0] = 0;
    #1 chk("t1 we after reset", 32'(mem_write_enable[0]), 32'h0);
    chk("t1 rsp after reset", 32'(ls_rsp_valid[0]), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    #1 chk("t1 no late rsp", 32'(ls_rsp_valid[0]), 32'h0);

    // contention with both requests held from reset
    @(posedge clk); #1;
    rst_n = 1'b0;
    if_req[0] = 1; if_addr[0] = 32'h4; ls_req[0] = 1; ls_we[0] = 0; ls_addr[0] = 32'h8;
    for (int i = 0; i < 4; i++) begin side[i] = -1; rc[i] = -1; rdv[i] = 32'hx; end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      @(negedge clk); #1;
      if (if_rsp_valid[0]) begin side[n] = 0; rc[n] = cyc; rdv[n] = if_rdata[0]; n++; end
      else if (ls_rsp_valid[0]) begin side[n] = 1; rc[n] = cyc; rdv[n] = ls_rdata[0]; n++; end
    end
    @(posedge clk); #1;
    if_req[0] = 0; ls_req[0] = 0;
    chk("t4 response count", 32'(n), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t4 side %0d", i), 32'(side[i]), 32'(i % 2));
      chk($sformatf("t4 cycle %0d", i), 32'(rc[i]), 32'(4 + 4 * i));
      chk($sformatf("t4 data %0d", i), rdv[i], (i % 2 == 0) ? 32'h10000001 : 32'h10000002);
    end

    // aligned fetch
    fetch(0, 32'h10, t0, tr, d, e);
    chk("t2 latency", 32'(tr - t0), 32'd3);
    chk("t2 rdata", d, 32'hDEADBEEF);
    chk("t2 err", 32'(e), 32'h0);

    // partial store then load of the merged word
    ls_op(0, 1'b1, 32'h20, 32'h12345678, 4'b0011, t0, tr, d, wc, rd4);
    chk("t3 store latency", 32'(tr - t0), 32'd3);
    chk("t3 store we pulses", 32'(wc), 32'd1);
    chk("t3 store rdata", d, 32'h0);
    ls_op(0, 1'b0, 32'h22, 32'h0, 4'h0, t0, tr, d, wc, rd4);
    chk("t3 load merged", d, 32'h10005678);
    chk("t3 load we pulses", 32'(wc), 32'd0);

    // store with no byte enables is still acknowledged and changes nothing
    ls_op(0, 1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, t0, tr, d, wc, rd4);
    chk("be0 store latency", 32'(tr - t0), 32'd3);
    ls_op(0, 1'b0, 32'h24, 32'h0, 4'h0, t0, tr, d, wc, rd4);
    chk("be0 load unchanged", d, 32'h10000009);

    // top-of-range address
    ls_op(0, 1'b0, 32'hFFFFFFFE, 32'h0, 4'h0, t0, tr, d, wc, rd4);
    chk("wrap load", d, 32'h1000003F);

    // misaligned fetch
    fetch(0, 32'h13, t0, tr, d, e);
    chk("t5 latency", 32'(tr - t0), 32'd2);
    chk("t5 err", 32'(e), 32'h1);
    chk("t5 rdata", d, 32'h0);

    // longer memory latency
    ls_op(1, 1'b0, 32'h30, 32'h0, 4'h0, t0, tr, d, wc, rd4);
    chk("t6 latency", 32'(tr - t0), 32'd5);
    chk("t6 rdata", d, 32'h1000000C);
    chk("t6 mem data at T+4", rd4, 32'h1000000C);
    fetch(1, 32'h10, t0, tr, d, e);
    chk("t6 fetch latency", 32'(tr - t0), 32'd5);
    chk("t6 fetch rdata", d, 32'hDEADBEEF);

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end
endmodule
